// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by STRELA memory nodes and bus endpoints.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/strela_pkg.sv
// STRELA subsystem-wide constants and small helpers.
package strela_pkg;

  localparam logic [31:0] OBI_ERR_DATA = 32'hBADCAB1E;

  // 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting towards bit 0.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-depth valid/data delay line; data reads as zero whenever the output is not valid.
module obi_resp_pipe #(
  parameter int unsigned Depth     = 1,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o
);

  logic [Depth-1:0]                valid_d, valid_q;
  logic [Depth-1:0][DataWidth-1:0] data_d, data_q;

  always_comb begin
    valid_d    = '0;
    data_d     = '0;
    valid_d[0] = valid_i;
    data_d[0]  = valid_i ? data_i : '0;
    for (int i = 1; i < int'(Depth); i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign data_o  = valid_q[Depth-1] ? data_q[Depth-1] : '0;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI slave memory model: byte-enabled word array, fixed-latency in-order responses and
// optional LFSR-driven grant stalls.
module obi_mem_responder
  import obi_pkg::*;
  import strela_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter bit          STALL_EN  = 1'b0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  req_i,
  output obi_resp_t resp_o
);

  localparam int unsigned IdxW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [31:0] NumWordsW = 32'(NUM_WORDS);

  logic [15:0]     lfsr_d, lfsr_q;
  logic            stall, gnt, accept, in_range;
  logic [29:0]     idx;
  logic [IdxW-1:0] widx;
  logic [31:0]     rd_word, resp_data;
  logic            rvalid;
  logic [31:0]     rdata;
  logic [31:0]     mem_q [NUM_WORDS];

  always_comb lfsr_d = lfsr16_next(lfsr_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign stall  = STALL_EN & lfsr_q[0];
  assign gnt    = req_i.req & ~stall;
  assign accept = gnt;

  // Addresses below ADDR_BASE wrap to huge indices and fall out of range.
  assign idx       = 30'((req_i.addr - ADDR_BASE) >> 2);
  assign in_range  = {2'b00, idx} < NumWordsW;
  assign widx      = idx[IdxW-1:0];
  assign rd_word   = in_range ? mem_q[widx] : OBI_ERR_DATA;
  assign resp_data = req_i.we ? 32'h0 : rd_word;

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk_i) begin
    if (accept && req_i.we && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (req_i.be[k]) mem_q[widx][8*k +: 8] <= req_i.wdata[8*k +: 8];
      end
    end
  end

  obi_resp_pipe #(
    .Depth     (LATENCY),
    .DataWidth (32)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (accept),
    .data_i  (resp_data),
    .valid_o (rvalid),
    .data_o  (rdata)
  );

  always_comb begin
    resp_o        = '0;
    resp_o.gnt    = gnt;
    resp_o.rvalid = rvalid;
    resp_o.rdata  = rdata;
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder across three parameterisations.
module tb_obi_mem_responder;
  import obi_pkg::*;

  logic      clk;
  logic      rst_a, rst_b, rst_c;
  obi_req_t  req_a, req_b, req_c;
  obi_resp_t resp_a, resp_b, resp_c;
  int        n_checks;
  int        n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: basic + byte enables; b: offset base, small array, deep pipe; c: grant stalling.
  obi_mem_responder #(
    .NUM_WORDS (64), .LATENCY (1), .ADDR_BASE (32'h0), .STALL_EN (1'b0), .LFSR_SEED (16'hACE1)
  ) u_a (.clk_i (clk), .rst_i (rst_a), .req_i (req_a), .resp_o (resp_a));

  obi_mem_responder #(
    .NUM_WORDS (16), .LATENCY (3), .ADDR_BASE (32'h1000), .STALL_EN (1'b0), .LFSR_SEED (16'hACE1)
  ) u_b (.clk_i (clk), .rst_i (rst_b), .req_i (req_b), .resp_o (resp_b));

  obi_mem_responder #(
    .NUM_WORDS (16), .LATENCY (2), .ADDR_BASE (32'h0), .STALL_EN (1'b1), .LFSR_SEED (16'hACE1)
  ) u_c (.clk_i (clk), .rst_i (rst_c), .req_i (req_c), .resp_o (resp_c));

  function automatic obi_req_t mk_req(input logic r, input logic w, input logic [3:0] b,
                                      input logic [31:0] ad, input logic [31:0] wd);
    obi_req_t q;
    q.req   = r;
    q.we    = w;
    q.be    = b;
    q.addr  = ad;
    q.wdata = wd;
    return q;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    req_a = '0; req_b = '0;
    req_c = mk_req(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (resp_a.rvalid !== 1'b0 || resp_a.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_a_resp: got rvalid=%b rdata=%h want 0/00000000",
               resp_a.rvalid, resp_a.rdata);
    end
    n_checks++;
    if (resp_a.gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_a_gnt: got %b want 0", resp_a.gnt);
    end
    n_checks++;
    if (resp_b.rvalid !== 1'b0 || resp_b.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_b_resp: got rvalid=%b rdata=%h want 0/00000000",
               resp_b.rvalid, resp_b.rdata);
    end
    // Seed 0xACE1 has bit 0 set, so the stalling instance must hold off grant.
    n_checks++;
    if (resp_c.gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_c_gnt_seed: got %b want 0", resp_c.gnt);
    end
    @(negedge clk);
    req_c = '0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    req_a = mk_req(1'b1, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
    #1;
    n_checks++;
    if (resp_a.gnt !== 1'b1 || resp_a.rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wr_issue: got gnt=%b rvalid=%b want 1/0", resp_a.gnt, resp_a.rvalid);
    end
    @(negedge clk);
    req_a = mk_req(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    #1;
    n_checks++;
    if (resp_a.rvalid !== 1'b1 || resp_a.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_wr_resp: got rvalid=%b rdata=%h want 1/00000000",
               resp_a.rvalid, resp_a.rdata);
    end
    @(negedge clk);
    req_a = '0;
    #1;
    n_checks++;
    if (resp_a.rvalid !== 1'b1 || resp_a.rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL basic_rd_resp: got rvalid=%b rdata=%h want 1/12345678",
               resp_a.rvalid, resp_a.rdata);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_a.rvalid !== 1'b0 || resp_a.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_idle: got rvalid=%b rdata=%h want 0/00000000",
               resp_a.rvalid, resp_a.rdata);
    end
  endtask

  task automatic test_byte_enable();
    logic        we_t [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  be_t [8] = '{4'hF, 4'h1, 4'hF, 4'h0, 4'hF, 4'hA, 4'hF, 4'hF};
    logic [31:0] ad_t [8] = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h10};
    logic [31:0] wd_t [8] = '{32'hFFFF_FFFF, 32'h0000_00AA, 32'h0, 32'h1234_5678, 32'h0,
                              32'h1122_3344, 32'h0, 32'h0};
    logic [31:0] ex_t [8] = '{32'h0, 32'h0, 32'hFFFF_FFAA, 32'h0, 32'hFFFF_FFAA, 32'h0,
                              32'h11FF_33AA, 32'h1234_5678};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) req_a = mk_req(1'b1, we_t[i], be_t[i], ad_t[i], wd_t[i]);
      else       req_a = '0;
      #1;
      if (i > 0) begin
        n_checks++;
        if (resp_a.rvalid !== 1'b1 || resp_a.rdata !== ex_t[i-1]) begin
          n_fail++;
          $display("FAIL byte_enable op%0d: got rvalid=%b rdata=%h want 1/%h",
                   i - 1, resp_a.rvalid, resp_a.rdata, ex_t[i-1]);
        end
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_a.rvalid !== 1'b0) begin
      n_fail++; $display("FAIL byte_enable_tail: got rvalid=%b want 0", resp_a.rvalid);
    end
  endtask

  task automatic test_range();
    logic        we_t [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ad_t [8] = '{32'h1000, 32'h103C, 32'h1040, 32'h0FFC, 32'h1040, 32'h1000,
                              32'h103E, 32'h1003};
    logic [31:0] wd_t [8] = '{32'hCAFE_F00D, 32'h3C, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0,
                              32'h0};
    logic [31:0] ex_t [8] = '{32'h0, 32'h0, 32'hBADC_AB1E, 32'hBADC_AB1E, 32'h0, 32'hCAFE_F00D,
                              32'h3C, 32'hCAFE_F00D};
    for (int j = 0; j <= 11; j++) begin
      @(negedge clk);
      if (j < 8) req_b = mk_req(1'b1, we_t[j], 4'hF, ad_t[j], wd_t[j]);
      else       req_b = '0;
      #1;
      n_checks++;
      if (j >= 3 && j - 3 < 8) begin
        if (resp_b.rvalid !== 1'b1 || resp_b.rdata !== ex_t[j-3]) begin
          n_fail++;
          $display("FAIL range op%0d: got rvalid=%b rdata=%h want 1/%h",
                   j - 3, resp_b.rvalid, resp_b.rdata, ex_t[j-3]);
        end
      end else if (resp_b.rvalid !== 1'b0 || resp_b.rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL range_idle cyc%0d: got rvalid=%b rdata=%h want 0/00000000",
                 j, resp_b.rvalid, resp_b.rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    for (int j = 0; j <= 19; j++) begin
      @(negedge clk);
      if (j < 8)       req_b = mk_req(1'b1, 1'b1, 4'hF, 32'h1000 + 32'(4 * j), 32'(j));
      else if (j < 16) req_b = mk_req(1'b1, 1'b0, 4'hF, 32'h1000 + 32'(4 * (j - 8)), 32'h0);
      else             req_b = '0;
      #1;
      n_checks++;
      if (j >= 3 && j - 3 < 16) begin
        exp_d = (j - 3 < 8) ? 32'h0 : 32'(j - 11);
        if (resp_b.rvalid !== 1'b1 || resp_b.rdata !== exp_d) begin
          n_fail++;
          $display("FAIL b2b op%0d: got rvalid=%b rdata=%h want 1/%h",
                   j - 3, resp_b.rvalid, resp_b.rdata, exp_d);
        end
      end else if (resp_b.rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_idle cyc%0d: got rvalid=%b want 0", j, resp_b.rvalid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      req_b = mk_req(1'b1, 1'b0, 4'hF, 32'h1004 + 32'(4 * j), 32'h0);
    end
    @(negedge clk);
    req_b = '0;
    #1;
    n_checks++;
    if (resp_b.rvalid !== 1'b1 || resp_b.rdata !== 32'h1) begin
      n_fail++;
      $display("FAIL midrst_first: got rvalid=%b rdata=%h want 1/00000001",
               resp_b.rvalid, resp_b.rdata);
    end
    #2;
    rst_b = 1'b1;
    #1;
    n_checks++;
    if (resp_b.rvalid !== 1'b0 || resp_b.rdata !== 32'h0 || resp_b.gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got rvalid=%b rdata=%h gnt=%b want 0/00000000/0",
               resp_b.rvalid, resp_b.rdata, resp_b.gnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (resp_b.rvalid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_stale cyc%0d: got rvalid=%b want 0", j, resp_b.rvalid);
      end
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0)      req_b = mk_req(1'b1, 1'b0, 4'hF, 32'h103C, 32'h0);
      else if (j == 1) req_b = mk_req(1'b1, 1'b0, 4'hF, 32'h1014, 32'h0);
      else             req_b = '0;
      #1;
      if (j == 3 || j == 4) begin
        n_checks++;
        if (resp_b.rvalid !== 1'b1 || resp_b.rdata !== ((j == 3) ? 32'h3C : 32'h5)) begin
          n_fail++;
          $display("FAIL midrst_retained rd%0d: got rvalid=%b rdata=%h want 1/%h", j - 3,
                   resp_b.rvalid, resp_b.rdata, (j == 3) ? 32'h3C : 32'h5);
        end
      end
    end
  endtask

  task automatic test_stall();
    localparam int NumOps = 216;
    logic [31:0] mm [16];
    int          due_q [$];
    logic [31:0] dat_q [$];
    logic [15:0] m_lfsr;
    logic        holding, exp_gnt;
    obi_req_t    cur;
    int          op, cyc, dut_acc, dut_rv, idx;
    logic [31:0] exp_d;

    @(negedge clk);
    rst_c = 1'b1;
    req_c = '0;
    @(negedge clk);
    rst_c   = 1'b0;
    m_lfsr  = 16'hACE1;
    holding = 1'b0;
    cur     = '0;
    op = 0; cyc = 0; dut_acc = 0; dut_rv = 0;
    while (cyc < 3000 && (op < NumOps || due_q.size() > 0)) begin
      if (!holding) begin
        cur = '0;
        if (op < 16) begin
          cur = mk_req(1'b1, 1'b1, 4'hF, 32'(4 * op), 32'hA500_0000 | 32'(op));
          holding = 1'b1;
        end else if (op < NumOps && $urandom_range(0, 3) != 0) begin
          cur = mk_req(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       32'(4 * $urandom_range(0, 19) + $urandom_range(0, 3)), $urandom);
          holding = 1'b1;
        end
      end
      req_c = cur;
      #1;
      exp_gnt = cur.req & ~m_lfsr[0];
      n_checks++;
      if (resp_c.gnt !== exp_gnt) begin
        n_fail++;
        $display("FAIL stall_gnt cyc%0d: got %b want %b", cyc, resp_c.gnt, exp_gnt);
      end
      n_checks++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        exp_d = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
        if (resp_c.rvalid !== 1'b1 || resp_c.rdata !== exp_d) begin
          n_fail++;
          $display("FAIL stall_resp cyc%0d: got rvalid=%b rdata=%h want 1/%h",
                   cyc, resp_c.rvalid, resp_c.rdata, exp_d);
        end
      end else if (resp_c.rvalid !== 1'b0 || resp_c.rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL stall_bubble cyc%0d: got rvalid=%b rdata=%h want 0/00000000",
                 cyc, resp_c.rvalid, resp_c.rdata);
      end
      if (resp_c.rvalid === 1'b1) dut_rv++;
      n_checks++;
      if (dut_acc - dut_rv > 2) begin
        n_fail++;
        $display("FAIL stall_outstanding cyc%0d: got %0d want <=2", cyc, dut_acc - dut_rv);
      end
      if (resp_c.gnt === 1'b1 && cur.req) dut_acc++;
      if (cur.req && exp_gnt) begin
        idx   = int'(cur.addr >> 2);
        exp_d = 32'h0;
        if (cur.we) begin
          if (idx < 16) begin
            for (int k = 0; k < 4; k++) if (cur.be[k]) mm[idx][8*k +: 8] = cur.wdata[8*k +: 8];
          end
        end else begin
          exp_d = (idx < 16) ? mm[idx] : 32'hBADC_AB1E;
        end
        due_q.push_back(cyc + 2);
        dat_q.push_back(exp_d);
        holding = 1'b0;
        op++;
      end
      @(negedge clk);
      m_lfsr = lfsr_step(m_lfsr);
      cyc++;
    end
    req_c = '0;
    n_checks++;
    if (op != NumOps || due_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_timeout: got ops=%0d pending=%0d want %0d/0", op, due_q.size(),
               NumOps);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_byte_enable();
    test_range();
    test_back_to_back();
    test_reset_midflight();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit reached want finish");
    $fatal(1);
  end

endmodule
